hamming_dec: RTL and testbench
==============================

Name: hamming_dec

Overview:
- Pipelined Hamming single-error-correcting decoder; the receive-side counterpart of `hamming_enc`.
- Takes a data word and its PW parity bits, computes the syndrome, corrects any single-bit error in the data, and flags uncorrectable patterns.
- Sits on the read path of ECC-protected NPU buffers and streams words through a valid/ready handshake.

Parameters:
- DW, 10, data width in bits.
- PW, 4, parity width in bits; must satisfy 2^PW >= DW+PW+1.
- CNT_W, 16, error-counter width; used only with the optional feature.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input word valid.
- o_ready  out  1  decoder can accept an input word.
- i_dec_data  in  DW  received data.
- i_parity  in  PW  received parity.
- o_valid  out  1  output word valid.
- i_ready  in  1  downstream accepts the output word.
- o_dec_data  out  DW  corrected data.
- o_syndrome  out  PW  raw syndrome of the word.
- o_err_corr  out  1  single-bit error detected and corrected (data bit or parity bit).
- o_err_uncorr  out  1  syndrome is out of range; data is passed through uncorrected.

Behaviour:
- Bit positions:
  - TW = DW+PW; positions are 1-based, 1..TW.
  - Parity bit i occupies position 2^i.
  - Data bit j occupies the j-th position that is not a power of two, in ascending order. For the defaults: 3,5,6,7,9,10,11,12,13,14.
- Syndrome: S[i] = i_parity[i] XOR (XOR of every data bit j whose position has bit i set).
- Classification of S:
  - S==0: clean word; data unchanged; both flags 0.
  - S == 2^i: parity bit i is in error; data unchanged; o_err_corr=1.
  - S equals the position of data bit j: invert data bit j; o_err_corr=1.
  - S > TW: o_err_uncorr=1; data unchanged; o_err_corr=0.
- Pipeline:
  - Stage 1 registers the input data and S.
  - Stage 2 registers the corrected data, S, and both flags.
  - Latency is 2 cycles from input handshake to o_valid when there is no backpressure. Throughput is 1 word/cycle.
- Handshake:
  - An input transfer occurs when i_valid && o_ready.
  - An output transfer occurs when o_valid && i_ready.
  - Stage 2 advances when it is empty or i_ready=1. Stage 1 advances when it is empty or stage 2 advances. o_ready equals "stage 1 advances".
  - The ready path is combinational from i_ready to o_ready; no skid buffer.
  - While o_valid=1 && i_ready=0, all outputs hold stable.
  - A simultaneous output transfer and new input transfer must not drop or duplicate words.
- Reset:
  - i_rst clears both stage valid bits. o_valid=0 and o_ready=1 in the first cycle after reset.
  - o_dec_data, o_syndrome and both flags reset to 0.
  - In-flight words are discarded on reset mid-stream. No output is produced for them afterwards.
- Data outputs are don't-care while o_valid=0 (except at reset).

Optional Feature:
- Macro: HAMMING_DEC_ERR_CNT_EN.
- Defined:
  - Add input i_cnt_clr (1 bit).
  - Add outputs o_corr_cnt (CNT_W) and o_uncorr_cnt (CNT_W).
  - Each counter increments by 1 on every output transfer whose corresponding flag is 1.
  - Counters saturate at all-ones.
  - Reset or i_cnt_clr sets both counters to 0. Clear wins over a same-cycle increment.
- Undefined: these ports and registers do not exist; the decode path is identical in both builds.

Test Plan (defaults DW=10, PW=4):
- Clean word: data 10'h3FF, parity 4'h0, i_ready=1 → 2 cycles later o_dec_data=10'h3FF, o_syndrome=0, both flags 0.
- Data-bit error: data 10'h001, parity 4'h0 → o_syndrome=4'h3, o_dec_data=10'h000, o_err_corr=1. Repeat for all 10 single-bit flips of 10'h000 → each is corrected to 10'h000.
- Parity-bit error: data 10'h000, parity 4'h4 → o_syndrome=4'h4, o_dec_data=10'h000, o_err_corr=1, o_err_uncorr=0.
- Uncorrectable: data 10'h081 (positions 3 and 12 flipped), parity 4'h0 → o_syndrome=4'hF, o_err_uncorr=1, o_err_corr=0, o_dec_data=10'h081.
- Backpressure: stream 5 words back-to-back with i_ready low for 3 cycles mid-stream:
  - o_ready drops only when both stages are full.
  - Outputs hold stable while stalled.
  - All 5 words exit in order with no loss or duplication.
  - Assert i_rst with 2 words in flight → o_valid=0 next cycle and neither word appears.
- With HAMMING_DEC_ERR_CNT_EN:
  - Send 3 correctable words and 1 uncorrectable word → o_corr_cnt=3, o_uncorr_cnt=1.
  - Pulse i_cnt_clr → both counters 0.
  - CNT_W=2 with 5 correctable words → o_corr_cnt saturates at 3.

Source files
------------

// File: rtl/hamming_dec.sv
// hamming_dec -- pipelined Hamming single-error-correcting decoder.
//
// Receive-side counterpart of hamming_enc. Each word arrives with PW parity
// bits. The decoder computes the syndrome, inverts the data bit it points at,
// and flags syndromes that point past the end of the codeword. Codeword
// positions run 1..DW+PW. Parity bit i sits at position 2^i. Data bits fill
// the remaining positions in ascending order.
//
// The pipeline has two stages and a combinational ready path with no skid
// buffer. Latency is 2 cycles and throughput is 1 word/cycle.
//
// Optional feature (macro HAMMING_DEC_ERR_CNT_EN): saturating counters of
// corrected and uncorrectable words seen on output transfers, cleared by
// i_cnt_clr.
//
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_valid        input word valid
//   o_ready        decoder can accept an input word
//   i_dec_data     received data (DW)
//   i_parity       received parity (PW)
//   o_valid        output word valid
//   i_ready        downstream accepts the output word
//   o_dec_data     corrected data (DW)
//   o_syndrome     raw syndrome (PW)
//   o_err_corr     single-bit error corrected (data or parity bit)
//   o_err_uncorr   syndrome out of range, data passed through unchanged
//   i_cnt_clr      (feature only) clear both error counters
//   o_corr_cnt     (feature only) count of corrected words (CNT_W)
//   o_uncorr_cnt   (feature only) count of uncorrectable words (CNT_W)
module hamming_dec #(
    parameter int DW    = 10,
    parameter int PW    = 4,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [DW-1:0]    i_dec_data,
    input  logic [PW-1:0]    i_parity,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [DW-1:0]    o_dec_data,
    output logic [PW-1:0]    o_syndrome,
    output logic             o_err_corr,
`ifdef HAMMING_DEC_ERR_CNT_EN
    output logic             o_err_uncorr,
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] o_corr_cnt,
    output logic [CNT_W-1:0] o_uncorr_cnt
`else
    output logic             o_err_uncorr
`endif
);

    localparam int TW = DW + PW;
    localparam logic [PW-1:0] TW_P = PW'(TW);
    localparam bit PARAMS_OK = ((2 ** PW) >= (TW + 1)) && (CNT_W >= 1);

    if (!PARAMS_OK) begin : g_bad_params
        $error("hamming_dec: PW too small for DW, or CNT_W < 1");
    end

    // Position of data bit j: the j-th non-power-of-two position, 1-based.
    function automatic logic [PW-1:0] data_pos(input int j);
        int k;
        k = 0;
        data_pos = '0;
        for (int p = 1; p <= TW; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (k == j) data_pos = PW'(p);
                k++;
            end
        end
    endfunction

    logic              vld_p1, vld_p2;
    logic              adv_p1, adv_p2;
    logic [PW-1:0]     syn_p0;
    logic [DW-1:0]     data_p1;
    logic [PW-1:0]     syn_p1;
    logic [DW-1:0]     flip_p1;
    logic              corr_p1, uncorr_p1;
    logic [DW-1:0]     data_p2;
    logic [PW-1:0]     syn_p2;
    logic              corr_p2, uncorr_p2;

    // Stage 2 moves when it is empty or drained. Stage 1 moves when it is
    // empty or stage 2 moves.
    assign adv_p2  = !vld_p2 || i_ready;
    assign adv_p1  = !vld_p1 || adv_p2;
    assign o_ready = adv_p1;

    // ---- stage 0: syndrome of the incoming word ----
    always_comb begin
        syn_p0 = i_parity;
        for (int j = 0; j < DW; j++) begin
            if (i_dec_data[j]) syn_p0 = syn_p0 ^ data_pos(j);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p1 <= 1'b0;
        end else if (adv_p1) begin
            vld_p1 <= i_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (adv_p1 && i_valid) begin
            data_p1 <= i_dec_data;
            syn_p1  <= syn_p0;
        end
    end

    // ---- stage 1: classify syndrome, build correction mask ----
    always_comb begin
        flip_p1   = '0;
        corr_p1   = (syn_p1 != '0) && (syn_p1 <= TW_P);
        uncorr_p1 = (syn_p1 > TW_P);
        for (int j = 0; j < DW; j++) begin
            flip_p1[j] = (syn_p1 == data_pos(j));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p2    <= 1'b0;
            data_p2   <= '0;
            syn_p2    <= '0;
            corr_p2   <= 1'b0;
            uncorr_p2 <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2   <= data_p1 ^ flip_p1;
                syn_p2    <= syn_p1;
                corr_p2   <= corr_p1;
                uncorr_p2 <= uncorr_p1;
            end
        end
    end

    // ---- stage 2: outputs ----
    assign o_valid      = vld_p2;
    assign o_dec_data   = data_p2;
    assign o_syndrome   = syn_p2;
    assign o_err_corr   = corr_p2;
    assign o_err_uncorr = uncorr_p2;

`ifdef HAMMING_DEC_ERR_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] corr_cnt, uncorr_cnt;

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (o_valid && i_ready) begin
            if (o_err_corr)   corr_cnt   <= sat_inc(corr_cnt);
            if (o_err_uncorr) uncorr_cnt <= sat_inc(uncorr_cnt);
        end
    end

    assign o_corr_cnt   = corr_cnt;
    assign o_uncorr_cnt = uncorr_cnt;
`endif

endmodule

// File: tb/tb_hamming_dec.sv
// Testbench for hamming_dec. Directed vectors from the decoder's rules plus
// randomized streams checked against a codeword-level reference model.
module tb_hamming_dec;

    localparam int DW    = 10;
    localparam int PW    = 4;
    localparam int TW    = DW + PW;
    localparam int CNT_W = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid, o_ready, o_valid, i_ready;
    logic [DW-1:0] i_dec_data, o_dec_data;
    logic [PW-1:0] i_parity, o_syndrome;
    logic          o_err_corr, o_err_uncorr;
`ifdef HAMMING_DEC_ERR_CNT_EN
    logic             i_cnt_clr;
    logic [CNT_W-1:0] o_corr_cnt, o_uncorr_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int n_in   = 0;
    int n_out  = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [PW-1:0] s;
        logic          c;
        logic          u;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    hamming_dec #(.DW(DW), .PW(PW), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_dec_data   (i_dec_data),
        .i_parity     (i_parity),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_dec_data   (o_dec_data),
        .o_syndrome   (o_syndrome),
        .o_err_corr   (o_err_corr),
`ifdef HAMMING_DEC_ERR_CNT_EN
        .o_err_uncorr (o_err_uncorr),
        .i_cnt_clr    (i_cnt_clr),
        .o_corr_cnt   (o_corr_cnt),
        .o_uncorr_cnt (o_uncorr_cnt)
`else
        .o_err_uncorr (o_err_uncorr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: lay out the full codeword, XOR positions of set bits,
    // flip the addressed position if it exists, read the data back out.
    function automatic exp_t model(input logic [DW-1:0] d, input logic [PW-1:0] p);
        logic cw [1:TW];
        int   di, pi, s;
        exp_t r;
        di = 0; pi = 0; s = 0;
        for (int pos = 1; pos <= TW; pos++) begin
            if ((pos & (pos - 1)) == 0) begin
                cw[pos] = p[pi];
                pi++;
            end else begin
                cw[pos] = d[di];
                di++;
            end
            if (cw[pos]) s = s ^ pos;
        end
        r.s = s[PW-1:0];
        r.c = 1'b0;
        r.u = 1'b0;
        if (s > TW) begin
            r.u = 1'b1;
        end else if (s != 0) begin
            r.c = 1'b1;
            cw[s] = ~cw[s];
        end
        di = 0;
        r.d = '0;
        for (int pos = 1; pos <= TW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                r.d[di] = cw[pos];
                di++;
            end
        end
        return r;
    endfunction

    // One isolated word with no backpressure; checks 2-cycle latency.
    task automatic run_one(input string tag, input logic [DW-1:0] d, input logic [PW-1:0] p,
                           input logic [DW-1:0] ed, input logic [PW-1:0] es,
                           input logic ec, input logic eu);
        @(negedge clk);
        i_valid = 1'b1; i_ready = 1'b1; i_dec_data = d; i_parity = p;
        #1;
        check({tag, "_ready"}, 32'(o_ready), 32'(1));
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        check({tag, "_lat1"}, 32'(o_valid), 32'(0));
        @(negedge clk);
        #1;
        check({tag, "_valid"}, 32'(o_valid), 32'(1));
        check({tag, "_data"}, 32'(o_dec_data), 32'(ed));
        check({tag, "_syn"}, 32'(o_syndrome), 32'(es));
        check({tag, "_corr"}, 32'(o_err_corr), 32'(ec));
        check({tag, "_uncorr"}, 32'(o_err_uncorr), 32'(eu));
    endtask

    // mode 0: 5 words back-to-back, i_ready low in cycles 2..4
    // mode 1: random valid/ready; mode 2: drain
    task automatic stream(input int ncyc, input int mode);
        int   sent;
        bit   stall;
        exp_t held, got, e;
        sent = 0; stall = 1'b0; held = '0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            if (mode == 0) begin
                i_valid = (sent < 5);
                i_ready = !(cyc >= 2 && cyc <= 4);
            end else if (mode == 1) begin
                i_valid = ($urandom_range(0, 3) != 0);
                i_ready = ($urandom_range(0, 3) != 0);
            end else begin
                i_valid = 1'b0;
                i_ready = 1'b1;
            end
            i_dec_data = DW'($urandom);
            i_parity   = PW'($urandom);
            #1;
            got = {o_dec_data, o_syndrome, o_err_corr, o_err_uncorr};
            check("ready_full", 32'(o_ready), (q.size() == 2 && !i_ready) ? 32'(0) : 32'(1));
            if (stall) begin
                check("hold_valid", 32'(o_valid), 32'(1));
                check("hold_out", 32'(got), 32'(held));
            end
            if (o_valid && i_ready) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    n_out++;
                    check("str_data", 32'(o_dec_data), 32'(e.d));
                    check("str_syn", 32'(o_syndrome), 32'(e.s));
                    check("str_corr", 32'(o_err_corr), 32'(e.c));
                    check("str_uncorr", 32'(o_err_uncorr), 32'(e.u));
                end else begin
                    check("phantom_word", 32'(o_valid), 32'(0));
                end
            end
            if (i_valid && o_ready) begin
                q.push_back(model(i_dec_data, i_parity));
                sent++;
                n_in++;
            end
            stall = o_valid && !i_ready;
            held  = got;
        end
    endtask

    logic [DW-1:0] dpos [DW];
    int            base_in, base_out;
    exp_t          m;
    logic [DW-1:0] rd;
    logic [PW-1:0] rp;

    initial begin
        dpos = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14};
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_dec_data = '0; i_parity = '0;
`ifdef HAMMING_DEC_ERR_CNT_EN
        i_cnt_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", 32'(o_valid), 32'(0));
        check("rst_ready", 32'(o_ready), 32'(1));
        check("rst_data", 32'(o_dec_data), 32'(0));
        check("rst_syn", 32'(o_syndrome), 32'(0));
        check("rst_flags", 32'({o_err_corr, o_err_uncorr}), 32'(0));
        rst = 1'b0;

        run_one("clean", 10'h3FF, 4'h0, 10'h3FF, 4'h0, 1'b0, 1'b0);
        for (int j = 0; j < DW; j++) begin
            rd = '0;
            rd[j] = 1'b1;
            run_one($sformatf("dflip%0d", j), rd, 4'h0, 10'h000, PW'(dpos[j]), 1'b1, 1'b0);
        end
        run_one("pflip", 10'h000, 4'h4, 10'h000, 4'h4, 1'b1, 1'b0);
        run_one("uncorr", 10'h081, 4'h0, 10'h081, 4'hF, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            rd = DW'($urandom);
            rp = PW'($urandom);
            m  = model(rd, rp);
            run_one($sformatf("rnd%0d", k), rd, rp, m.d, m.s, m.c, m.u);
        end

        base_in = n_in; base_out = n_out;
        stream(12, 0);
        stream(6, 2);
        check("bp_in", 32'(n_in - base_in), 32'(5));
        check("bp_out", 32'(n_out - base_out), 32'(5));
        check("bp_empty", 32'(q.size()), 32'(0));

        stream(300, 1);
        stream(8, 2);
        check("rnd_empty", 32'(q.size()), 32'(0));

        // Two words stuck in the pipe, then reset.
        @(negedge clk);
        i_ready = 1'b0; i_valid = 1'b1; i_dec_data = 10'h155; i_parity = 4'h1;
        @(negedge clk);
        i_dec_data = 10'h2AA; i_parity = 4'h2;
        @(negedge clk);
        #1;
        check("pre_rst_full", 32'(o_ready), 32'(0));
        i_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_valid", 32'(o_valid), 32'(0));
        check("mrst_ready", 32'(o_ready), 32'(1));
        check("mrst_data", 32'(o_dec_data), 32'(0));
        check("mrst_syn", 32'(o_syndrome), 32'(0));
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("mrst_no_out", 32'(o_valid), 32'(0));
        end

`ifdef HAMMING_DEC_ERR_CNT_EN
        @(negedge clk);
        i_cnt_clr = 1'b1;
        @(negedge clk);
        i_cnt_clr = 1'b0;
        #1;
        check("cnt_init_c", 32'(o_corr_cnt), 32'(0));
        check("cnt_init_u", 32'(o_uncorr_cnt), 32'(0));
        run_one("c0", 10'h001, 4'h0, 10'h000, 4'h3, 1'b1, 1'b0);
        run_one("c1", 10'h002, 4'h0, 10'h000, 4'h5, 1'b1, 1'b0);
        run_one("c2", 10'h000, 4'h1, 10'h000, 4'h1, 1'b1, 1'b0);
        run_one("u0", 10'h081, 4'h0, 10'h081, 4'hF, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        check("cnt_corr", 32'(o_corr_cnt), 32'(3));
        check("cnt_uncorr", 32'(o_uncorr_cnt), 32'(1));
        i_cnt_clr = 1'b1;
        @(negedge clk);
        i_cnt_clr = 1'b0;
        #1;
        check("cnt_clr_c", 32'(o_corr_cnt), 32'(0));
        check("cnt_clr_u", 32'(o_uncorr_cnt), 32'(0));
        for (int k = 0; k < 5; k++) begin
            run_one($sformatf("s%0d", k), 10'h004, 4'h0, 10'h000, 4'h6, 1'b1, 1'b0);
        end
        @(negedge clk);
        #1;
        check("cnt_sat", 32'(o_corr_cnt), 32'(3));
        check("cnt_sat_u", 32'(o_uncorr_cnt), 32'(0));
        run_one("cw", 10'h008, 4'h0, 10'h000, 4'h7, 1'b1, 1'b0);
        i_cnt_clr = 1'b1;
        @(negedge clk);
        i_cnt_clr = 1'b0;
        #1;
        check("cnt_clr_wins", 32'(o_corr_cnt), 32'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
